// File: rtl/pio_in_debounce_irq.sv
// rtl/pio_in_debounce_irq.sv - Avalon-MM input PIO bank with synchronisers, debounce, edge capture and masked IRQ
module pio_in_debounce_irq #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_next;
    logic             wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Each bit has its own counter so a bouncing key never delays its neighbours.
    for (genvar b = 0; b < WIDTH; b++) begin : g_deb
        logic stable_b;
        assign stable[b] = stable_b;

        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stable_b <= 1'b0;
                else          stable_b <= sync[b];
            end
        end else begin : g_filter
            logic [CW-1:0] cnt;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_b <= 1'b0;
                    cnt      <= '0;
                end else if (sync[b] == stable_b) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_b <= sync[b];
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    assign wr   = chipselect & ~write_n;
    assign rise = stable & ~stable_d & rise_en;
    assign fall = ~stable & stable_d & fall_en;
    assign w1c  = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

    // New edges are OR-ed in after the clear so a same-cycle event is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d     <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            rise_en      <= '1;
            fall_en      <= '1;
        end else begin
            stable_d     <= stable;
            edge_capture <= (edge_capture & ~w1c) | rise | fall;
            if (wr && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
            if (wr && address == 3'd4) rise_en  <= writedata[WIDTH-1:0];
            if (wr && address == 3'd5) fall_en  <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            3'd0:    rd_next[WIDTH-1:0] = stable;
            3'd1:    rd_next[WIDTH-1:0] = sync;
            3'd2:    rd_next[WIDTH-1:0] = irq_mask;
            3'd3:    rd_next[WIDTH-1:0] = edge_capture;
            3'd4:    rd_next[WIDTH-1:0] = rise_en;
            3'd5:    rd_next[WIDTH-1:0] = fall_en;
            3'd6:    rd_next            = 32'(DEBOUNCE_CYCLES);
            default: rd_next            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// tb/tb_pio_in_debounce_irq.sv - randomized and directed bench for pio_in_debounce_irq against a window-based model
module tb_pio_in_debounce_irq;

    localparam int W = 4;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0] rd4, rd0;
    logic        irq4, irq0;

    int n_checks = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    pio_in_debounce_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd4), .irq(irq4));

    pio_in_debounce_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));

    // Model: index 0 has a 4-sample debounce window, index 1 is bypassed.
    logic [W-1:0] m_sp [2][S];
    logic [W-1:0] m_win [4];
    logic [W-1:0] m_stable [2];
    logic [W-1:0] m_sd [2];
    logic [W-1:0] m_edge [2];
    logic [W-1:0] m_mask [2];
    logic [W-1:0] m_re [2];
    logic [W-1:0] m_fe [2];
    logic [31:0]  m_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input int m, input logic [2:0] a);
        case (a)
            3'd0:    return {28'd0, m_stable[m]};
            3'd1:    return {28'd0, m_sp[m][S-1]};
            3'd2:    return {28'd0, m_mask[m]};
            3'd3:    return {28'd0, m_edge[m]};
            3'd4:    return {28'd0, m_re[m]};
            3'd5:    return {28'd0, m_fe[m]};
            3'd6:    return (m == 0) ? 32'd4 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < S; i++) m_sp[m][i] = '0;
            m_stable[m] = '0; m_sd[m] = '0; m_edge[m] = '0; m_mask[m] = '0;
            m_re[m] = '1; m_fe[m] = '1; m_rd[m] = '0;
        end
        for (int i = 0; i < 4; i++) m_win[i] = '0;
    endtask

    task automatic model_step(input int m);
        logic [W-1:0] sync, ev, clr;
        logic wr, all_diff;
        sync = m_sp[m][S-1];
        wr = chipselect && !write_n;
        m_rd[m] = reg_val(m, address);
        ev = (m_stable[m] & ~m_sd[m] & m_re[m]) | (~m_stable[m] & m_sd[m] & m_fe[m]);
        clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
        m_edge[m] = (m_edge[m] & ~clr) | ev;
        if (wr && address == 3'd2) m_mask[m] = writedata[W-1:0];
        if (wr && address == 3'd4) m_re[m] = writedata[W-1:0];
        if (wr && address == 3'd5) m_fe[m] = writedata[W-1:0];
        m_sd[m] = m_stable[m];
        if (m == 1) begin
            m_stable[m] = sync;
        end else begin
            // Accept a bit once the last four synchronised samples all disagree with it.
            for (int i = 0; i < 3; i++) m_win[i] = m_win[i+1];
            m_win[3] = sync;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (m_win[i][b] == m_stable[m][b]) all_diff = 1'b0;
                if (all_diff) m_stable[m][b] = ~m_stable[m][b];
            end
        end
        for (int i = S - 1; i > 0; i--) m_sp[m][i] = m_sp[m][i-1];
        m_sp[m][0] = in_port;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("rd_d4", rd4, m_rd[0]);
            chk("irq_d4", {31'd0, irq4}, {31'd0, |(m_edge[0] & m_mask[0])});
            chk("rd_d0", rd0, m_rd[1]);
            chk("irq_d0", {31'd0, irq0}, {31'd0, |(m_edge[1] & m_mask[1])});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    logic [31:0] exp_rst [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'hF, 32'h4, 32'h0};

    initial begin
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        check_en = 1'b1;

        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            tick();
            chk("reset_rd_d4", rd4, exp_rst[a]);
            chk("reset_rd_d0", rd0, (a == 6) ? 32'h0 : exp_rst[a]);
        end
        chk("reset_irq", {31'd0, irq4}, 32'd0);

        wr(3'd2, 32'h1);
        address = 3'd0;
        in_port = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3) begin chk("byp_data_early", rd0, 32'h0); chk("byp_irq_early", {31'd0, irq0}, 32'd0); end
            if (k == 4) begin chk("byp_data", rd0, 32'h1); chk("byp_irq", {31'd0, irq0}, 32'd1); end
            if (k == 6) begin chk("data_early", rd4, 32'h0); chk("irq_early", {31'd0, irq4}, 32'd0); end
            if (k == 7) begin chk("data_lat", rd4, 32'h1); chk("irq_lat", {31'd0, irq4}, 32'd1); end
        end

        wr(3'd3, 32'hF);
        in_port = 4'h3; repeat (3) tick();
        in_port = 4'h1; repeat (12) tick();
        address = 3'd3; tick();
        chk("glitch3_edge", rd4, 32'h0);
        address = 3'd0; tick();
        chk("glitch3_data", rd4, 32'h1);
        chk("glitch3_irq", {31'd0, irq4}, 32'd0);
        in_port = 4'h3; repeat (4) tick();
        in_port = 4'h1; repeat (12) tick();
        address = 3'd3; tick();
        chk("pulse4_edge", rd4, 32'h2);
        wr(3'd3, 32'hF);

        wr(3'd4, 32'h0);
        wr(3'd5, 32'h2);
        in_port = 4'h3; repeat (10) tick();
        address = 3'd3; tick();
        chk("rise_dis_edge", rd4, 32'h0);
        in_port = 4'h1; repeat (10) tick();
        tick();
        chk("fall_en_edge", rd4, 32'h2);
        wr(3'd4, 32'hF);
        wr(3'd5, 32'hF);
        wr(3'd3, 32'hF);

        in_port = 4'h2; repeat (10) tick();
        address = 3'd3; tick();
        chk("edge_both", rd4, 32'h3);
        in_port = 4'h3;
        repeat (6) tick();
        wr(3'd3, 32'h1);
        address = 3'd3; tick();
        chk("w1c_collision", rd4, 32'h3);
        wr(3'd3, 32'h2);
        tick();
        chk("w1c_bit1", rd4, 32'h1);
        wr(3'd3, 32'h0);
        tick();
        chk("w1c_zero", rd4, 32'h1);

        wr(3'd2, 32'hF);
        chk("pre_reset_irq", {31'd0, irq4}, 32'd1);
        in_port = 4'h0; repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_irq", {31'd0, irq4}, 32'd0);
        chk("rst_rd", rd4, 32'h0);
        chk("rst_irq_d0", {31'd0, irq0}, 32'd0);
        tick();
        reset_n = 1'b1;
        address = 3'd0;
        in_port = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3) chk("rst_byp_early", rd0, 32'h0);
            if (k == 4) chk("rst_byp_data", rd0, 32'hF);
            if (k == 6) chk("rst_data_early", rd4, 32'h0);
            if (k == 7) chk("rst_data_lat", rd4, 32'hF);
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            reset_n    = ($urandom_range(0, 999) != 0);
            tick();
        end
        reset_n = 1'b1;
        chipselect = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
